// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg: shared types and constants for the LEGv8 multicycle control unit.
//   - state_t   : FSM states. S_TRAP exists only when CU_TRAP_EN is defined.
//   - kind_t    : instruction class that steers the EXEC/MEM/WB sequence.
//   - ctrl_t    : packed control bundle produced by cu_decode.
//   - opc_pat_t : opcode value/mask pairs. Mask bits set to 1 must match.
// Configuration macro: CU_TRAP_EN (adds the TRAP state).
// ---------------------------------------------------------------------------
package cu_pkg;

  localparam int OPC_BITS    = 11;
  localparam int ALUOP_BITS  = 3;
  localparam int SEU_BITS    = 2;
  localparam int ALUSRC_BITS = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
`ifdef CU_TRAP_EN
    , S_TRAP = 3'd6
`endif
  } state_t;

  // K_NOP must be the all-zero code so that a reset or cleared bundle is a NOP.
  typedef enum logic [2:0] {
    K_NOP  = 3'd0,
    K_ALU  = 3'd1,
    K_LD   = 3'd2,
    K_ST   = 3'd3,
    K_B    = 3'd4,
    K_CBZ  = 3'd5,
    K_CBNZ = 3'd6
  } kind_t;

  // ALU operation select
  localparam logic [ALUOP_BITS-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALUOP_BITS-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALUOP_BITS-1:0] ALU_AND  = 3'b010;
  localparam logic [ALUOP_BITS-1:0] ALU_ORR  = 3'b011;
  localparam logic [ALUOP_BITS-1:0] ALU_PASS = 3'b100;
  localparam logic [ALUOP_BITS-1:0] ALU_LSL  = 3'b101;

  // Immediate-extender select
  localparam logic [SEU_BITS-1:0] SEU_ALU = 2'b00;
  localparam logic [SEU_BITS-1:0] SEU_D   = 2'b01;
  localparam logic [SEU_BITS-1:0] SEU_B   = 2'b10;
  localparam logic [SEU_BITS-1:0] SEU_CB  = 2'b11;

  // ALU operand-B source
  localparam logic [ALUSRC_BITS-1:0] SRC_REG   = 2'b00;
  localparam logic [ALUSRC_BITS-1:0] SRC_IMM   = 2'b01;
  localparam logic [ALUSRC_BITS-1:0] SRC_SHAMT = 2'b10;

  typedef struct packed {
    kind_t                   kind;
    logic                    reg2loc;
    logic [SEU_BITS-1:0]     seu;
    logic [ALUSRC_BITS-1:0]  alusrc;
    logic [ALUOP_BITS-1:0]   aluop;
    logic                    memtoreg;
  } ctrl_t;

  typedef struct packed {
    logic [OPC_BITS-1:0] val;
    logic [OPC_BITS-1:0] msk;
  } opc_pat_t;

  localparam logic [OPC_BITS-1:0] M_ALL = 11'b111_1111_1111;
  localparam logic [OPC_BITS-1:0] M_I   = 11'b111_1111_1110;
  localparam logic [OPC_BITS-1:0] M_CB  = 11'b111_1111_1000;
  localparam logic [OPC_BITS-1:0] M_B   = 11'b111_1110_0000;

  localparam opc_pat_t PAT_AND  = '{val: 11'b10001010000, msk: M_ALL};
  localparam opc_pat_t PAT_ORR  = '{val: 11'b10101010000, msk: M_ALL};
  localparam opc_pat_t PAT_ADD  = '{val: 11'b10001011000, msk: M_ALL};
  localparam opc_pat_t PAT_SUB  = '{val: 11'b11001011000, msk: M_ALL};
  localparam opc_pat_t PAT_ADDI = '{val: 11'b10010001000, msk: M_I};
  localparam opc_pat_t PAT_SUBI = '{val: 11'b11010001000, msk: M_I};
  localparam opc_pat_t PAT_ANDI = '{val: 11'b10010010000, msk: M_I};
  localparam opc_pat_t PAT_ORRI = '{val: 11'b10110010000, msk: M_I};
  localparam opc_pat_t PAT_LDUR = '{val: 11'b11111000010, msk: M_ALL};
  localparam opc_pat_t PAT_STUR = '{val: 11'b11111000000, msk: M_ALL};
  localparam opc_pat_t PAT_LSL  = '{val: 11'b11010011011, msk: M_ALL};
  localparam opc_pat_t PAT_B    = '{val: 11'b00010100000, msk: M_B};
  localparam opc_pat_t PAT_CBZ  = '{val: 11'b10110100000, msk: M_CB};
  localparam opc_pat_t PAT_CBNZ = '{val: 11'b10110101000, msk: M_CB};

  function automatic logic opc_is(input logic [OPC_BITS-1:0] opc, input opc_pat_t pat);
    return ((opc ^ pat.val) & pat.msk) == '0;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// ---------------------------------------------------------------------------
// cu_decode: combinational opcode -> control bundle decoder.
//   i_opcode : IR[31:21]
//   o_ctrl   : control bundle. Fields an instruction does not use are 0.
//   o_valid  : 1 when the opcode is recognised. An unrecognised opcode gives
//              o_valid = 0 and an all-zero (NOP) bundle.
// ---------------------------------------------------------------------------
module cu_decode
  import cu_pkg::*;
(
  input  logic [OPC_BITS-1:0] i_opcode,
  output ctrl_t               o_ctrl,
  output logic                o_valid
);

  // NOTE: every output gets a default before the decision chain; a path that
  // leaves an always_comb output unassigned infers a latch.
  always_comb begin
    o_ctrl  = '0;
    o_valid = 1'b1;
    if (opc_is(i_opcode, PAT_AND)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_AND;
    end else if (opc_is(i_opcode, PAT_ORR)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_ORR;
    end else if (opc_is(i_opcode, PAT_ADD)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_ADD;
    end else if (opc_is(i_opcode, PAT_SUB)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_SUB;
    end else if (opc_is(i_opcode, PAT_ADDI)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_ADD; o_ctrl.alusrc = SRC_IMM;
    end else if (opc_is(i_opcode, PAT_SUBI)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_SUB; o_ctrl.alusrc = SRC_IMM;
    end else if (opc_is(i_opcode, PAT_ANDI)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_AND; o_ctrl.alusrc = SRC_IMM;
    end else if (opc_is(i_opcode, PAT_ORRI)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_ORR; o_ctrl.alusrc = SRC_IMM;
    end else if (opc_is(i_opcode, PAT_LSL)) begin
      o_ctrl.kind = K_ALU; o_ctrl.aluop = ALU_LSL; o_ctrl.alusrc = SRC_SHAMT;
    end else if (opc_is(i_opcode, PAT_LDUR)) begin
      o_ctrl.kind   = K_LD;    o_ctrl.aluop    = ALU_ADD;
      o_ctrl.alusrc = SRC_IMM; o_ctrl.seu      = SEU_D;
      o_ctrl.memtoreg = 1'b1;
    end else if (opc_is(i_opcode, PAT_STUR)) begin
      o_ctrl.kind   = K_ST;    o_ctrl.aluop    = ALU_ADD;
      o_ctrl.alusrc = SRC_IMM; o_ctrl.seu      = SEU_D;
      o_ctrl.reg2loc = 1'b1;
    end else if (opc_is(i_opcode, PAT_B)) begin
      o_ctrl.kind = K_B; o_ctrl.seu = SEU_B;
    end else if (opc_is(i_opcode, PAT_CBZ)) begin
      // Rt is passed through the ALU so that zero reflects the tested register.
      o_ctrl.kind = K_CBZ; o_ctrl.seu = SEU_CB;
      o_ctrl.reg2loc = 1'b1; o_ctrl.aluop = ALU_PASS;
    end else if (opc_is(i_opcode, PAT_CBNZ)) begin
      o_ctrl.kind = K_CBNZ; o_ctrl.seu = SEU_CB;
      o_ctrl.reg2loc = 1'b1; o_ctrl.aluop = ALU_PASS;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// mc_ctrl_unit: multicycle LEGv8 control FSM.
//   Sequence: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> retire.
//   Inputs : clk, rst_n (async, active low), run, opcode, zero, imem_ready,
//            dmem_ready.
//   Strobes: imem_rd, ir_wr, pc_wr, pcsrc, mem_rd, mem_wr, reg_wr, instr_done,
//            illegal. Each is active only in its owning state.
//   Fields : reg2loc, seu, alusrc, aluop, memtoreg come straight from the
//            control bundle latched in DECODE. They are stable from EXEC
//            through retirement.
// Configuration macro: CU_TRAP_EN. When it is defined, an unrecognised opcode
// parks the FSM in TRAP with illegal=1 until reset. When it is undefined, the
// opcode retires from EXEC as a NOP.
// ---------------------------------------------------------------------------
module mc_ctrl_unit
  import cu_pkg::*;
#(
  parameter int OPC_W     = 11,
  parameter int ALUOP_W   = 3,
  parameter int IMM_SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_rd,
  output logic                 ir_wr,
  output logic                 pc_wr,
  output logic                 pcsrc,
  output logic                 reg2loc,
  output logic [IMM_SEL_W-1:0] seu,
  output logic [1:0]           alusrc,
  output logic [ALUOP_W-1:0]   aluop,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 memtoreg,
  output logic                 reg_wr,
  output logic                 instr_done,
  output logic                 illegal
);

  state_t r_state, w_next_state;
  ctrl_t  r_ctrl, w_dec_ctrl;
  logic   w_dec_valid;
  logic   w_retire;

  cu_decode u_decode (
    .i_opcode (opcode),
    .o_ctrl   (w_dec_ctrl),
    .o_valid  (w_dec_valid)
  );

  // NOTE: the bundle register is reset along with the state. This keeps the
  // field outputs at 0 coming out of reset instead of leaving them unknown.
  // NOTE: state elements use non-blocking assignments so that every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_ctrl <= w_dec_ctrl;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    imem_rd      = 1'b0;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pcsrc        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_wr       = 1'b0;
    illegal      = 1'b0;
    unique case (r_state)
      S_IDLE: if (run) w_next_state = S_FETCH;
      S_FETCH: begin
        imem_rd = 1'b1;
        if (imem_ready) begin
          ir_wr        = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef CU_TRAP_EN
        w_next_state = w_dec_valid ? S_EXEC : S_TRAP;
`else
        w_next_state = S_EXEC;
`endif
      end
      S_EXEC: begin
        unique case (r_ctrl.kind)
          K_B:      begin pc_wr = 1'b1; pcsrc = 1'b1;  w_retire = 1'b1; end
          K_CBZ:    begin pc_wr = 1'b1; pcsrc = zero;  w_retire = 1'b1; end
          K_CBNZ:   begin pc_wr = 1'b1; pcsrc = ~zero; w_retire = 1'b1; end
          K_LD, K_ST: w_next_state = S_MEM;
          K_ALU:      w_next_state = S_WB;
          default:  begin pc_wr = 1'b1; w_retire = 1'b1; end  // NOP
        endcase
      end
      S_MEM: begin
        if (r_ctrl.kind == K_LD) begin
          mem_rd = 1'b1;
          if (dmem_ready) w_next_state = S_WB;
        end else begin
          mem_wr = 1'b1;
          if (dmem_ready) begin
            pc_wr    = 1'b1;
            w_retire = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_wr   = 1'b1;
        pc_wr    = 1'b1;
        w_retire = 1'b1;
      end
`ifdef CU_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: w_next_state = S_IDLE;
    endcase
    // run is consulted only at retirement, so dropping it mid-instruction
    // lets the current instruction finish.
    if (w_retire) w_next_state = run ? S_FETCH : S_IDLE;
  end

  assign instr_done = w_retire;
  assign reg2loc    = r_ctrl.reg2loc;
  assign seu        = r_ctrl.seu;
  assign alusrc     = r_ctrl.alusrc;
  assign aluop      = r_ctrl.aluop;
  assign memtoreg   = r_ctrl.memtoreg;

  logic w_unused;
  assign w_unused = w_dec_valid;

endmodule
